instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the single-issue MIPS datapath, directly upstream of the opcode decoder. It holds the program counter, issues word requests to instruction memory over a req/ack handshake, and presents the fetched word plus PC+4 in an IF/ID register. Branch and jump redirects arrive from downstream, resolved from the decoder's beq/bne/Jump outputs and the ALU zero flag. A one-entry skid buffer absorbs a response that returns while the pipeline is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  word address, held stable while imem_req=1 and no ack
- imem_ack  in  1  response valid; may assert in the same cycle as imem_req
- imem_rdata  in  32  instruction word, valid with imem_ack
- stall  in  1  hold the IF/ID register (hazard unit)
- ex_valid  in  1  the redirect inputs below are meaningful
- jump, beq, bne  in  1 each  control bits of the resolving instruction
- alu_zero  in  1  ALU zero flag of the resolving instruction
- br_pc4  in  32  PC+4 of the resolving instruction
- br_imm  in  16  branch immediate
- j_idx  in  26  jump instruction index
- pc  out  32  current fetch PC
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  32  fetched instruction
- ifid_pc4  out  32  PC+4 of ifid_instr

## Operation
- Redirect is asserted when ex_valid & (jump | beq&alu_zero | bne&~alu_zero). Jump has priority over branch.
- Jump target is {br_pc4[31:28], j_idx, 2'b00}.
- Branch target is br_pc4 + (sext(br_imm) << 2), computed mod 2^32.
- Sequential PC is pc + 4, wrapping mod 2^32.
- FSM has two states: RUN and DRAIN.
- **RUN**
  - imem_req=1 whenever the skid buffer is empty; imem_addr=pc.
  - On imem_ack with no redirect, pc advances by 4.
  - The word is written to IF/ID if ifid_valid=0 or stall=0. Otherwise it is written to the skid buffer.
  - When stall=0 and the skid buffer is full, the skid entry moves to IF/ID. No new ack can land that cycle, because no request is outstanding while the skid is full.
  - With stall=0 and no new word, ifid_valid clears.
- **Redirect (from any state; overrides stall)**
  - ifid_valid and the skid buffer clear, and pc <= target.
  - If a request is outstanding and imem_ack=0, go to DRAIN.
  - If imem_ack=1 in the redirect cycle, the word is discarded and the FSM stays in RUN.
- **DRAIN**
  - imem_req stays high with the old address until imem_ack; the returned word is discarded.
  - On ack, go to RUN.
  - A further redirect in DRAIN updates pc only.
- Reset mid-fetch abandons the outstanding request. Memory must tolerate a dropped request.

## Timing
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc4=0, skid empty, state RUN.
- The first imem_req is asserted in the cycle after rst falls.
- With zero-wait memory (ack in the same cycle as req), IF/ID is loaded on the edge ending that cycle: one instruction per cycle, latency 1.
- IF/ID and the skid buffer update only on rising clk edges. All outputs are registered, except imem_req and imem_addr, which come from registered state.
- Redirect penalty with zero-wait memory: the first target word appears in IF/ID two edges after the redirect cycle.

## Configuration
- FETCH_BUBBLE_NOP_EN defined: ifid_instr is forced to 32'h0000_0000 (sll $0,$0,0) whenever ifid_valid=0, after reset, flush or drain. Downstream decoders may then ignore ifid_valid.
- FETCH_BUBBLE_NOP_EN undefined: ifid_instr keeps its last value when invalid. Consumers must gate on ifid_valid.

## Structure
- Shared package mips_pkg holds:
  - constants OP_RTYPE=6'h0, OP_J=6'h2, OP_BEQ=6'h4, OP_BNE=6'h5, NOP_INSTR=32'h0
  - the fetch state enum {RUN, DRAIN}
- One sub-module: next_pc_calc, a combinational block producing the target and redirect.

## Test plan
- Reset, then zero-wait memory returning addr-as-data → IF/ID shows 0x0, 0x4, 0x8 with ifid_pc4 = 0x4, 0x8, 0xC on consecutive cycles.
- stall=1 for 3 cycles while a 2-cycle-latency ack arrives → word held in skid, imem_req=0, IF/ID unchanged; the skid word enters IF/ID on the first edge after stall drops, and the PC sequence has no gaps.
- beq=1, alu_zero=1, br_pc4=0x100, br_imm=16'hFFFE during an outstanding fetch → pc=0xF8, the DRAIN response is discarded, the next request is at 0xF8.
- jump=1, j_idx=26'h40, br_pc4=0x1000_0010 with stall=1 → IF/ID flushed (valid=0) despite stall, pc=0x1000_0100.
- bne=1, alu_zero=1 → no redirect, sequential fetch continues.
- rst pulsed during a pending request → all outputs at reset values on the following edge; with FETCH_BUBBLE_NOP_EN, ifid_instr=0 throughout the flush and reset bubbles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants, fetch FSM encoding and target helpers.
// Imported by the fetch stage and its next-PC sub-block.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE  = 6'h0;
    localparam logic [5:0]  OP_J      = 6'h2;
    localparam logic [5:0]  OP_BEQ    = 6'h4;
    localparam logic [5:0]  OP_BNE    = 6'h5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_t;

    function automatic logic [31:0] jump_target(
        input logic [31:0] pc4,
        input logic [25:0] idx
    );
        return {pc4[31:28], idx, 2'b00};
    endfunction

    function automatic logic [31:0] branch_target(
        input logic [31:0] pc4,
        input logic [15:0] imm
    );
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Resolves branch/jump redirect and its target from downstream controls.
// Jump wins over a taken branch when both are present.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic        ex_valid,
    input  logic        jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        alu_zero,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_idx,
    output logic        redirect,
    output logic [31:0] target
);

    logic take_br;

    always_comb begin
        take_br  = (beq & alu_zero) | (bne & ~alu_zero);
        redirect = ex_valid & (jump | take_br);
        target   = jump ? jump_target(br_pc4, j_idx)
                        : branch_target(br_pc4, br_imm);
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, imem req/ack handshake, one-entry skid and IF/ID register.
// Define FETCH_BUBBLE_NOP_EN to force ifid_instr to NOP while ifid_valid=0.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        alu_zero,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_idx,
    output logic [31:0] pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4
);

`ifdef FETCH_BUBBLE_NOP_EN
    localparam bit BUBBLE_NOP = 1'b1;
`else
    localparam bit BUBBLE_NOP = 1'b0;
`endif

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic        active;
    logic [31:0] drain_addr;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic        redirect;
    logic [31:0] target;
    logic        accept;
    logic [31:0] pc_seq;

    next_pc_calc u_next_pc (
        .ex_valid (ex_valid),
        .jump     (jump),
        .beq      (beq),
        .bne      (bne),
        .alu_zero (alu_zero),
        .br_pc4   (br_pc4),
        .br_imm   (br_imm),
        .j_idx    (j_idx),
        .redirect (redirect),
        .target   (target)
    );

    assign pc_seq = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Request is held at the orphaned address in DRAIN until memory answers.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = pc;
        accept    = 1'b0;
        unique case (state)
            RUN: begin
                imem_req = active & ~skid_valid;
                accept   = imem_req & imem_ack;
                if (redirect && imem_req && !imem_ack) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (imem_ack) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active     <= 1'b0;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            skid_valid <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'h0;
        end else begin
            active <= 1'b1;
            if (state == RUN && state_nxt == DRAIN) begin
                drain_addr <= pc;
            end
            if (redirect) begin
                pc         <= target;
                ifid_valid <= 1'b0;
                skid_valid <= 1'b0;
                if (BUBBLE_NOP) ifid_instr <= NOP_INSTR;
            end else if (state == RUN) begin
                if (accept) pc <= pc_seq;
                // A full skid means no request is out, so no accept here.
                if (skid_valid) begin
                    if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_instr <= skid_instr;
                        ifid_pc4   <= skid_pc4;
                        skid_valid <= 1'b0;
                    end
                end else if (accept) begin
                    if (!ifid_valid || !stall) begin
                        ifid_valid <= 1'b1;
                        ifid_instr <= imem_rdata;
                        ifid_pc4   <= pc_seq;
                    end else begin
                        skid_valid <= 1'b1;
                        skid_instr <= imem_rdata;
                        skid_pc4   <= pc_seq;
                    end
                end else if (!stall) begin
                    ifid_valid <= 1'b0;
                    if (BUBBLE_NOP) ifid_instr <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, skid, redirects, reset.
// Memory model returns the address as data with a selectable ack latency.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        ex_valid;
    logic        jump;
    logic        beq;
    logic        bne;
    logic        alu_zero;
    logic [31:0] br_pc4;
    logic [15:0] br_imm;
    logic [25:0] j_idx;
    logic [31:0] pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;

    int unsigned mem_lat;
    int unsigned wait_cnt;
    int          errors = 0;
    int          checks = 0;

    instr_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .jump       (jump),
        .beq        (beq),
        .bne        (bne),
        .alu_zero   (alu_zero),
        .br_pc4     (br_pc4),
        .br_imm     (br_imm),
        .j_idx      (j_idx),
        .pc         (pc),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_ack   = imem_req && (wait_cnt >= mem_lat);
        imem_rdata = imem_addr;
    end

    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; ex_valid = 1'b0;
        jump = 1'b0; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
        br_pc4 = 32'h0; br_imm = 16'h0; j_idx = 26'h0;
        mem_lat = 0;

        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h0);
        tick();
        rst = 1'b0;
        chk("req_idle_at_release", {31'b0, imem_req}, 32'h0);
        tick();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        // Zero-wait streaming.
        tick();
        chk("s0_valid", {31'b0, ifid_valid}, 32'h1);
        chk("s0_instr", ifid_instr, 32'h0);
        chk("s0_pc4", ifid_pc4, 32'h4);
        tick();
        chk("s1_instr", ifid_instr, 32'h4);
        chk("s1_pc4", ifid_pc4, 32'h8);
        tick();
        chk("s2_instr", ifid_instr, 32'h8);
        chk("s2_pc4", ifid_pc4, 32'hC);
        chk("s2_pc", pc, 32'hC);

        // Stall while a 2-cycle response lands: goes to skid.
        mem_lat = 2; stall = 1'b1;
        tick(); tick(); tick();
        chk("skid_req_low", {31'b0, imem_req}, 32'h0);
        chk("skid_hold_instr", ifid_instr, 32'h8);
        chk("skid_hold_pc4", ifid_pc4, 32'hC);
        chk("skid_pc", pc, 32'h10);
        stall = 1'b0;
        tick();
        chk("skid_out_instr", ifid_instr, 32'hC);
        chk("skid_out_pc4", ifid_pc4, 32'h10);
        chk("skid_out_addr", imem_addr, 32'h10);
        mem_lat = 0;
        tick();
        chk("after_skid_instr", ifid_instr, 32'h10);
        chk("after_skid_pc", pc, 32'h14);

        // beq taken during an outstanding fetch -> DRAIN.
        mem_lat = 2;
        tick();
        ex_valid = 1'b1; beq = 1'b1; alu_zero = 1'b1;
        br_pc4 = 32'h100; br_imm = 16'hFFFE;
        tick();
        ex_valid = 1'b0; beq = 1'b0;
        chk("beq_pc", pc, 32'hF8);
        chk("drain_req", {31'b0, imem_req}, 32'h1);
        chk("drain_addr", imem_addr, 32'h14);
        chk("beq_valid", {31'b0, ifid_valid}, 32'h0);
`ifdef FETCH_BUBBLE_NOP_EN
        chk("beq_bubble_instr", ifid_instr, 32'h0);
`else
        chk("beq_bubble_instr", ifid_instr, 32'h10);
`endif
        tick();
        chk("drain_discard", {31'b0, ifid_valid}, 32'h0);
        chk("post_drain_addr", imem_addr, 32'hF8);
        chk("post_drain_req", {31'b0, imem_req}, 32'h1);
        mem_lat = 0;
        tick();
        chk("tgt_instr", ifid_instr, 32'hF8);
        chk("tgt_pc4", ifid_pc4, 32'hFC);

        // Jump under stall flushes IF/ID.
        stall = 1'b1; ex_valid = 1'b1; jump = 1'b1;
        j_idx = 26'h40; br_pc4 = 32'h1000_0010;
        tick();
        ex_valid = 1'b0; jump = 1'b0; stall = 1'b0;
        chk("jmp_valid", {31'b0, ifid_valid}, 32'h0);
        chk("jmp_pc", pc, 32'h1000_0100);
        chk("jmp_addr", imem_addr, 32'h1000_0100);
`ifdef FETCH_BUBBLE_NOP_EN
        chk("jmp_bubble_instr", ifid_instr, 32'h0);
`endif
        tick();
        chk("jmp_tgt_instr", ifid_instr, 32'h1000_0100);
        chk("jmp_tgt_pc4", ifid_pc4, 32'h1000_0104);

        // bne with zero flag set: not taken.
        ex_valid = 1'b1; bne = 1'b1; alu_zero = 1'b1;
        br_pc4 = 32'h200; br_imm = 16'h4;
        tick();
        ex_valid = 1'b0; bne = 1'b0;
        chk("bne_nt_instr", ifid_instr, 32'h1000_0104);
        chk("bne_nt_pc", pc, 32'h1000_0108);

        // Jump and taken beq together: jump wins.
        ex_valid = 1'b1; jump = 1'b1; beq = 1'b1; alu_zero = 1'b1;
        j_idx = 26'h3; br_pc4 = 32'h2000_0000; br_imm = 16'h10;
        tick();
        ex_valid = 1'b0; jump = 1'b0; beq = 1'b0;
        chk("jmp_prio_pc", pc, 32'h2000_000C);
        tick();
        chk("jmp_prio_instr", ifid_instr, 32'h2000_000C);

        // Reset while a request is pending.
        mem_lat = 2;
        tick();
        rst = 1'b1;
        tick();
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_req", {31'b0, imem_req}, 32'h0);
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst2_instr", ifid_instr, 32'h0);
        chk("rst2_pc4", ifid_pc4, 32'h0);
        rst = 1'b0; mem_lat = 0;
        tick();
        chk("rst2_first_req", {31'b0, imem_req}, 32'h1);
        tick();
        chk("rst2_fetch_instr", ifid_instr, 32'h0);
        chk("rst2_fetch_pc4", ifid_pc4, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
